ddr_word_deserializer: RTL and testbench



---
 rtl/ddr_word_deserializer.sv | 116 +++++++++++
 tb/tb_ddr_word_deserializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_word_deserializer.sv
// Assembles the serial HDR-DDR SDA bit stream into 20-bit words (preamble, data, parity).
// Optional macro DWD_PARITY_CHECK_EN builds the parity comparator; without it o_dwd_parity_err stays 0.
module ddr_word_deserializer #(
   parameter int WORD_BITS = 20
) (
   input  logic        i_dwd_clk,
   input  logic        i_dwd_rst_n,
   input  logic        i_dwd_en,
   input  logic        i_dwd_bit_valid,
   input  logic        i_dwd_bit,
   output logic [15:0] o_dwd_data,
   output logic [1:0]  o_dwd_preamble,
   output logic        o_dwd_parity_err,
   output logic        o_dwd_word_valid,
   output logic        o_dwd_frame_done,
   output logic        o_dwd_busy
);

   localparam logic [4:0] LAST_PRE_IDX  = 5'd1;
   localparam logic [4:0] LAST_DATA_IDX = 5'd17;
   localparam logic [4:0] LAST_BIT_IDX  = 5'(WORD_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_PARITY
   } state_t;

   state_t               state;
   logic [4:0]           bit_idx;
   logic [WORD_BITS-1:0] shift_reg;
   logic [WORD_BITS-1:0] word_next;
   logic                 accept;
   logic                 word_done;
   logic                 perr_next;
   logic [15:0]          data_reg;
   logic [1:0]           preamble_reg;
   logic                 perr_reg;
   logic                 valid_reg;
   logic                 busy_reg;

   assign accept    = i_dwd_bit_valid && (state != ST_IDLE);
   assign word_done = accept && (state == ST_PARITY) && (bit_idx == LAST_BIT_IDX);
   assign word_next = {shift_reg[WORD_BITS-2:0], i_dwd_bit};

`ifdef DWD_PARITY_CHECK_EN
   // Data bit Dk sits at word_next[k+2]; PA1 covers odd data bits, PA0 even bits inverted.
   logic [1:0] pa_exp;
   logic       unused_msb;
   assign pa_exp[1] = ^{word_next[17], word_next[15], word_next[13], word_next[11],
                        word_next[9],  word_next[7],  word_next[5],  word_next[3]};
   assign pa_exp[0] = ~(^{word_next[16], word_next[14], word_next[12], word_next[10],
                          word_next[8],  word_next[6],  word_next[4],  word_next[2]});
   assign perr_next  = (word_next[1:0] != pa_exp);
   assign unused_msb = shift_reg[WORD_BITS-1];
`else
   logic unused_bits;
   assign perr_next   = 1'b0;
   assign unused_bits = ^{shift_reg[WORD_BITS-1], word_next[1:0]};
`endif

   // A completing 20th bit wins over a simultaneous enable drop so the word is not lost.
   always_ff @(posedge i_dwd_clk) begin
      if (!i_dwd_rst_n) begin
         state        <= ST_IDLE;
         bit_idx      <= '0;
         shift_reg    <= '0;
         data_reg     <= '0;
         preamble_reg <= '0;
         perr_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (word_done) begin
            shift_reg    <= word_next;
            bit_idx      <= '0;
            busy_reg     <= 1'b0;
            data_reg     <= word_next[LAST_DATA_IDX:2];
            preamble_reg <= word_next[WORD_BITS-1:WORD_BITS-2];
            perr_reg     <= perr_next;
            valid_reg    <= 1'b1;
            state        <= i_dwd_en ? ST_PREAMBLE : ST_IDLE;
         end else if (!i_dwd_en) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            busy_reg <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: state <= ST_PREAMBLE;
               default: begin
                  if (accept) begin
                     shift_reg <= word_next;
                     bit_idx   <= bit_idx + 5'd1;
                     busy_reg  <= 1'b1;
                     if (bit_idx == LAST_PRE_IDX) begin
                        state <= ST_DATA;
                     end else if (bit_idx == LAST_DATA_IDX) begin
                        state <= ST_PARITY;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign o_dwd_data       = data_reg;
   assign o_dwd_preamble   = preamble_reg;
   assign o_dwd_parity_err = perr_reg;
   assign o_dwd_word_valid = valid_reg;
   assign o_dwd_frame_done = valid_reg;
   assign o_dwd_busy       = busy_reg;

endmodule

// File: tb/tb_ddr_word_deserializer.sv
// Self-checking bench for ddr_word_deserializer: table of whole words plus enable/reset corner sequences.
module tb_ddr_word_deserializer;

`ifdef DWD_PARITY_CHECK_EN
   localparam bit PARITY_BUILT = 1'b1;
`else
   localparam bit PARITY_BUILT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        bit_valid = 1'b0;
   logic        sda_bit = 1'b0;
   logic [15:0] data;
   logic [1:0]  preamble;
   logic        parity_err;
   logic        word_valid;
   logic        frame_done;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int pulse_count = 0;
   int pulse_cycle[$];

   ddr_word_deserializer #(.WORD_BITS(20)) dut (
      .i_dwd_clk        (clk),
      .i_dwd_rst_n      (rst_n),
      .i_dwd_en         (en),
      .i_dwd_bit_valid  (bit_valid),
      .i_dwd_bit        (sda_bit),
      .o_dwd_data       (data),
      .o_dwd_preamble   (preamble),
      .o_dwd_parity_err (parity_err),
      .o_dwd_word_valid (word_valid),
      .o_dwd_frame_done (frame_done),
      .o_dwd_busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (word_valid) begin
         pulse_count++;
         pulse_cycle.push_back(cycle);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [1:0]  pre;
      logic [15:0] data;
      logic [1:0]  par;
      logic        perr;
   } vec_t;

   vec_t vecs[6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sendBit(input logic b);
      @(negedge clk);
      bit_valid = 1'b1;
      sda_bit   = b;
   endtask

   task automatic sendBits(input logic [19:0] w, input int first, input int last);
      for (int i = first; i >= last; i--) sendBit(w[i]);
   endtask

   task automatic applyStimulus(input logic [1:0] p, input logic [15:0] d, input logic [1:0] pa);
      sendBits({p, d, pa}, 19, 0);
   endtask

   task automatic idleCycle();
      @(negedge clk);
      bit_valid = 1'b0;
      sda_bit   = 1'b0;
   endtask

   task automatic checkWord(input string name, input logic [1:0] p, input logic [15:0] d, input logic perr);
      checkOutput({name, "_valid"}, 32'(word_valid), 32'd1);
      checkOutput({name, "_frame_done"}, 32'(frame_done), 32'd1);
      checkOutput({name, "_data"}, 32'(data), 32'(d));
      checkOutput({name, "_preamble"}, 32'(preamble), 32'(p));
      checkOutput({name, "_perr"}, 32'(parity_err), 32'(perr & PARITY_BUILT));
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int pc0;
      $display("[TB] start, parity check built = %0d", PARITY_BUILT);
      vecs[0] = '{2'b11, 16'hA5C3, 2'b01, 1'b0};
      vecs[1] = '{2'b11, 16'hA5C3, 2'b00, 1'b1};
      vecs[2] = '{2'b10, 16'h0000, 2'b01, 1'b0};
      vecs[3] = '{2'b01, 16'hFFFF, 2'b01, 1'b0};
      vecs[4] = '{2'b01, 16'hFFFF, 2'b10, 1'b1};
      vecs[5] = '{2'b00, 16'h1234, 2'b00, 1'b0};

      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_data", 32'(data), 32'd0);
      checkOutput("reset_preamble", 32'(preamble), 32'd0);
      checkOutput("reset_perr", 32'(parity_err), 32'd0);
      checkOutput("reset_valid", 32'(word_valid), 32'd0);
      checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;

      // Whole words, one idle cycle between them
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].pre, vecs[v].data, vecs[v].par);
         idleCycle();
         #1;
         checkWord($sformatf("vec%0d", v), vecs[v].pre, vecs[v].data, vecs[v].perr);
         idleCycle();
         #1;
         checkOutput($sformatf("vec%0d_pulse_width", v), 32'(word_valid), 32'd0);
      end

      // Back-to-back words with strobes every cycle
      pc0 = pulse_count;
      applyStimulus(2'b11, 16'hA5C3, 2'b01);
      sendBit(1'b1);
      #1;
      checkWord("b2b_first", 2'b11, 16'hA5C3, 1'b0);
      sendBits({2'b10, 16'h0000, 2'b01}, 18, 0);
      idleCycle();
      #1;
      checkWord("b2b_second", 2'b10, 16'h0000, 1'b0);
      repeat (2) idleCycle();
      #1;
      checkOutput("b2b_pulse_count", 32'(pulse_count - pc0), 32'd2);
      if (pulse_cycle.size() >= 2)
         checkOutput("b2b_spacing", 32'(pulse_cycle[$] - pulse_cycle[$-1]), 32'd20);

      // Enable dropped mid-word, then a clean word
      pc0 = pulse_count;
      sendBits({2'b11, 16'hA5C3, 2'b01}, 19, 10);
      idleCycle();
      #1;
      checkOutput("partial_busy", 32'(busy), 32'd1);
      en = 1'b0;
      idleCycle();
      #1;
      checkOutput("drop_busy", 32'(busy), 32'd0);
      checkOutput("drop_data_kept", 32'(data), 32'h0000);
      en = 1'b1;
      applyStimulus(2'b01, 16'hFFFF, 2'b01);
      idleCycle();
      #1;
      checkWord("after_drop", 2'b01, 16'hFFFF, 1'b0);
      repeat (2) idleCycle();
      #1;
      checkOutput("drop_pulse_count", 32'(pulse_count - pc0), 32'd1);

      // Reset for one cycle after 15 bits
      pc0 = pulse_count;
      sendBits({2'b11, 16'hA5C3, 2'b01}, 19, 5);
      idleCycle();
      rst_n = 1'b0;
      idleCycle();
      #1;
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_data", 32'(data), 32'd0);
      checkOutput("rst_mid_preamble", 32'(preamble), 32'd0);
      checkOutput("rst_mid_valid", 32'(word_valid), 32'd0);
      rst_n = 1'b1;
      sendBits({2'b10, 16'h5A3C, 2'b01}, 19, 15);
      idleCycle();
      #1;
      checkOutput("rst_no_early_pulse", 32'(pulse_count - pc0), 32'd0);
      checkOutput("rst_restart_busy", 32'(busy), 32'd1);
      sendBits({2'b10, 16'h5A3C, 2'b01}, 14, 0);
      idleCycle();
      #1;
      checkOutput("rst_full_pulse", 32'(pulse_count - pc0), 32'd1);
      checkOutput("rst_full_data", 32'(data), 32'h5A3C);

      // Enable falls together with the 20th strobe
      pc0 = pulse_count;
      sendBits({2'b01, 16'hFFFF, 2'b01}, 19, 1);
      sendBit(1'b1);
      en = 1'b0;
      idleCycle();
      #1;
      checkWord("en_fall_last", 2'b01, 16'hFFFF, 1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      idleCycle();
      #1;
      checkOutput("en_fall_idle_busy", 32'(busy), 32'd0);

      // Strobes while disabled are ignored
      applyStimulus(2'b11, 16'hA5C3, 2'b01);
      #1;
      checkOutput("disabled_busy_mid", 32'(busy), 32'd0);
      idleCycle();
      idleCycle();
      #1;
      checkOutput("disabled_busy", 32'(busy), 32'd0);
      checkOutput("disabled_pulses", 32'(pulse_count - pc0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
